bitmask_set_bit_enumerator: RTL and testbench

Accepts a word over a valid/ready handshake and emits every set bit of that word, rightmost (least-significant) first, one per output handshake. Each output carries the bit as a one-hot mask, as a binary index, and a last flag. Per cycle it clears the rightmost 1 bit of a held word (word & (word - 1)). It sits downstream of request or flag vectors that need per-bit service, such as interrupt pending bits, free-list slots, or scoreboard entries.

---
 rtl/bitmask_set_bit_enumerator_pkg.sv | 22 ++
 rtl/bitmask_isolate_rightmost_1_bit.sv | 12 +
 rtl/bitmask_set_bit_enumerator.sv | 92 +++++++++
 tb/tb_bitmask_set_bit_enumerator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bitmask_set_bit_enumerator_pkg.sv
// Shared definitions for the set-bit enumerator: FSM state encoding and a
// clog2 helper for instantiators sizing INDEX_WIDTH.
package bitmask_set_bit_enumerator_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Smallest r with 2**r >= value; constant-foldable for parameter use.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/bitmask_isolate_rightmost_1_bit.sv
// Isolates the least-significant set bit of a word: word & (~word + 1).
// A zero word yields zero.
module bitmask_isolate_rightmost_1_bit #(
   parameter int WORD_WIDTH = 8
) (
   input  logic [WORD_WIDTH-1:0] word,
   output logic [WORD_WIDTH-1:0] one_hot
);

   assign one_hot = word & (~word + WORD_WIDTH'(1));

endmodule

// File: rtl/bitmask_set_bit_enumerator.sv
// Accepts a word and emits each set bit LSB-first as one-hot, index and
// last flag, one per output handshake, with no bubble between words.
module bitmask_set_bit_enumerator
   import bitmask_set_bit_enumerator_pkg::*;
#(
   parameter int WORD_WIDTH  = 8,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   word_in_valid,
   output logic                   word_in_ready,
   input  logic [WORD_WIDTH-1:0]  word_in,
   output logic                   bit_out_valid,
   input  logic                   bit_out_ready,
   output logic [WORD_WIDTH-1:0]  bit_out_one_hot,
   output logic [INDEX_WIDTH-1:0] bit_out_index,
   output logic                   bit_out_last
);

   state_t                  state;
   state_t                  state_next;
   logic [WORD_WIDTH-1:0]   held;
   logic [WORD_WIDTH-1:0]   held_next;
   logic [WORD_WIDTH-1:0]   held_cleared;
   logic [WORD_WIDTH-1:0]   one_hot;
   logic [INDEX_WIDTH-1:0]  index;
   logic                    is_last;
   logic                    out_fire;
   logic                    in_fire;

   bitmask_isolate_rightmost_1_bit #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_isolate (
      .word    (held),
      .one_hot (one_hot)
   );

   // Held word is zero whenever the FSM is IDLE, so one_hot/index are zero
   // there too; only last needs explicit gating.
   assign held_cleared    = held & (held - WORD_WIDTH'(1));
   assign bit_out_valid   = (state == EMIT);
   assign is_last         = bit_out_valid && (held_cleared == '0);
   assign out_fire        = bit_out_valid && bit_out_ready;
   assign word_in_ready   = (state == IDLE) || (out_fire && is_last);
   assign in_fire         = word_in_valid && word_in_ready;

   assign bit_out_one_hot = one_hot;
   assign bit_out_index   = index;
   assign bit_out_last    = is_last;

   // Each index bit is the OR of the one-hot lines whose position has it set.
   always_comb begin
      index = '0;
      for (int b = 0; b < INDEX_WIDTH; b++) begin
         for (int i = 0; i < WORD_WIDTH; i++) begin
            if (((i >> b) & 1) != 0) begin
               index[b] = index[b] | one_hot[i];
            end
         end
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      state_next = state;
      held_next  = held;
      if (out_fire) begin
         held_next = held_cleared;
         if (is_last) begin
            state_next = IDLE;
         end
      end
      // A new word overrides the retirement of the previous one.
      if (in_fire) begin
         held_next  = word_in;
         state_next = (word_in != '0) ? EMIT : IDLE;
      end
   end

   // NOTE: non-blocking assignments for registered state avoid ordering races.
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         held  <= '0;
      end else begin
         state <= state_next;
         held  <= held_next;
      end
   end

endmodule

// File: tb/tb_bitmask_set_bit_enumerator.sv
// Self-checking bench: a queue of pending bit indices models the enumerator;
// directed scenarios plus randomized traffic are compared every cycle.
module tb_bitmask_set_bit_enumerator;
   import bitmask_set_bit_enumerator_pkg::*;

   localparam int W  = 8;
   localparam int IW = clog2(W);

   logic          clock;
   logic          clear;
   logic          word_in_valid;
   logic          word_in_ready;
   logic [W-1:0]  word_in;
   logic          bit_out_valid;
   logic          bit_out_ready;
   logic [W-1:0]  bit_out_one_hot;
   logic [IW-1:0] bit_out_index;
   logic          bit_out_last;

   int checks   = 0;
   int failures = 0;
   int q[$];
   bit compare_en = 0;

   bitmask_set_bit_enumerator #(
      .WORD_WIDTH  (W),
      .INDEX_WIDTH (IW)
   ) dut (
      .clock           (clock),
      .clear           (clear),
      .word_in_valid   (word_in_valid),
      .word_in_ready   (word_in_ready),
      .word_in         (word_in),
      .bit_out_valid   (bit_out_valid),
      .bit_out_ready   (bit_out_ready),
      .bit_out_one_hot (bit_out_one_hot),
      .bit_out_index   (bit_out_index),
      .bit_out_last    (bit_out_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs follow from the pending-index queue and current inputs.
   task automatic compare_model();
      logic          e_valid;
      logic          e_ready;
      logic [W-1:0]  e_one_hot;
      logic [IW-1:0] e_index;
      logic          e_last;
      e_valid   = (q.size() > 0);
      e_last    = (q.size() == 1);
      e_ready   = (q.size() == 0) || (bit_out_ready && e_last);
      e_one_hot = e_valid ? (W'(1) << q[0]) : '0;
      e_index   = e_valid ? IW'(q[0]) : '0;
      check("valid",   32'(bit_out_valid),   32'(e_valid));
      check("ready",   32'(word_in_ready),   32'(e_ready));
      check("one_hot", 32'(bit_out_one_hot), 32'(e_one_hot));
      check("index",   32'(bit_out_index),   32'(e_index));
      check("last",    32'(bit_out_last),    32'(e_last));
   endtask

   task automatic update_model();
      bit out_fire;
      bit in_ready;
      if (clear) begin
         q.delete();
      end else begin
         out_fire = (q.size() > 0) && bit_out_ready;
         in_ready = (q.size() == 0) || (out_fire && q.size() == 1);
         if (out_fire) void'(q.pop_front());
         if (word_in_valid && in_ready) begin
            for (int i = 0; i < W; i++) begin
               if (word_in[i]) q.push_back(i);
            end
         end
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] w, input logic r, input logic c);
      @(negedge clock);
      word_in_valid = v;
      word_in       = w;
      bit_out_ready = r;
      clear         = c;
      #1;
      if (compare_en) compare_model();
   endtask

   task automatic tick();
      @(posedge clock);
      update_model();
   endtask

   initial begin
      int hs;
      word_in_valid = 1'b0;
      word_in       = '0;
      bit_out_ready = 1'b0;
      clear         = 1'b1;

      // Reset: state is unknown before the first edge, so compare afterwards.
      drive(1'b0, '0, 1'b0, 1'b1); tick();
      compare_en = 1;
      drive(1'b1, 8'h55, 1'b1, 1'b1);
      check("rst_ready", 32'(word_in_ready), 32'd1);
      check("rst_valid", 32'(bit_out_valid), 32'd0);
      check("rst_last",  32'(bit_out_last),  32'd0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      check("post_rst_onehot", 32'(bit_out_one_hot), 32'd0);
      check("post_rst_index",  32'(bit_out_index),   32'd0);
      tick();

      // 8'b1010_1000 with ready high.
      drive(1'b1, 8'hA8, 1'b1, 1'b0); tick();
      check("model_a8_size", 32'(q.size()), 32'd3);
      check("model_a8_head", 32'(q[0]),     32'd3);
      drive(1'b0, '0, 1'b1, 1'b0);
      check("a8_idx0", 32'(bit_out_index), 32'd3);
      check("a8_oh0",  32'(bit_out_one_hot), 32'h08);
      check("a8_last0", 32'(bit_out_last), 32'd0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("a8_idx1", 32'(bit_out_index), 32'd5);
      check("a8_oh1",  32'(bit_out_one_hot), 32'h20);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("a8_idx2", 32'(bit_out_index), 32'd7);
      check("a8_oh2",  32'(bit_out_one_hot), 32'h80);
      check("a8_last2", 32'(bit_out_last), 32'd1);
      check("a8_ready2", 32'(word_in_ready), 32'd1);
      tick();

      // Zero word consumed silently.
      drive(1'b1, 8'h00, 1'b1, 1'b0); tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("zero_valid", 32'(bit_out_valid), 32'd0);
      check("zero_ready", 32'(word_in_ready), 32'd1);
      tick();

      // 8'hFF with ready toggling: outputs hold during stalls.
      drive(1'b1, 8'hFF, 1'b0, 1'b0); tick();
      hs = 0;
      for (int c = 0; c < 16; c++) begin
         drive(1'b0, '0, (c % 2 == 0), 1'b0);
         if (bit_out_valid && bit_out_ready) begin
            check("ff_index", 32'(bit_out_index), 32'(hs));
            hs++;
         end
         tick();
      end
      check("ff_handshakes", 32'(hs), 32'd8);

      // Back-to-back 8'h81 then 8'h02.
      drive(1'b1, 8'h81, 1'b1, 1'b0); tick();
      drive(1'b1, 8'h02, 1'b1, 1'b0);
      check("b2b_idx0", 32'(bit_out_index), 32'd0);
      check("b2b_rdy0", 32'(word_in_ready), 32'd0);
      tick();
      drive(1'b1, 8'h02, 1'b1, 1'b0);
      check("b2b_idx7", 32'(bit_out_index), 32'd7);
      check("b2b_last7", 32'(bit_out_last), 32'd1);
      check("b2b_rdy7", 32'(word_in_ready), 32'd1);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("b2b_idx1", 32'(bit_out_index), 32'd1);
      check("b2b_valid1", 32'(bit_out_valid), 32'd1);
      check("b2b_last1", 32'(bit_out_last), 32'd1);
      tick();

      // Clear mid-enumeration of 8'h0E.
      drive(1'b1, 8'h0E, 1'b1, 1'b0); tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("clr_first", 32'(bit_out_index), 32'd1);
      tick();
      drive(1'b0, '0, 1'b1, 1'b1); tick();
      drive(1'b1, 8'h40, 1'b1, 1'b0);
      check("clr_valid", 32'(bit_out_valid), 32'd0);
      check("clr_ready", 32'(word_in_ready), 32'd1);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("clr_idx6", 32'(bit_out_index), 32'd6);
      check("clr_last6", 32'(bit_out_last), 32'd1);
      tick();

      // Clear beats a simultaneous input handshake.
      drive(1'b1, 8'h01, 1'b1, 1'b1); tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      check("clr_in_valid", 32'(bit_out_valid), 32'd0);
      tick();

      // Randomized traffic with sparse words and occasional clears.
      for (int c = 0; c < 3000; c++) begin
         logic [W-1:0] w;
         w = W'($urandom);
         if ($urandom_range(0, 3) == 0) w = w & W'($urandom);
         if ($urandom_range(0, 15) == 0) w = '0;
         drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
               $urandom_range(0, 63) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
